// File: rtl/run_ctrl.sv
// Run controller: holds the core in reset, then runs it until a tohost mailbox
// write reports pass/fail or a cycle budget expires. All outputs are registered.
module run_ctrl #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                CNT_W          = 32,
  parameter int                RESET_CYCLES   = 4,
  parameter int                TIMEOUT_CYCLES = 300,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 'h0000_1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hit_reset,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              core_reset_n,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-2:0] fail_code,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int                HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t              state, state_d;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_d;
  logic                core_reset_n_d, running_d, done_d, pass_d, timeout_d;
  logic [DATA_W-2:0]   fail_code_d;
  logic [CNT_W-1:0]    cycle_count_d;
  logic                mbox_hit;

  // Only odd data at the mailbox address is a verdict; even values are progress chatter.
  assign mbox_hit = mem_valid && (mem_addr == TOHOST_ADDR) && mem_data[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_HOLD;
      hold_cnt     <= '0;
      core_reset_n <= 1'b0;
      running      <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      fail_code    <= '0;
      cycle_count  <= '0;
    end else begin
      state        <= state_d;
      hold_cnt     <= hold_cnt_d;
      core_reset_n <= core_reset_n_d;
      running      <= running_d;
      done         <= done_d;
      pass         <= pass_d;
      timeout      <= timeout_d;
      fail_code    <= fail_code_d;
      cycle_count  <= cycle_count_d;
    end
  end

  always_comb begin
    state_d        = state;
    hold_cnt_d     = hold_cnt;
    core_reset_n_d = core_reset_n;
    done_d         = done;
    pass_d         = pass;
    timeout_d      = timeout;
    fail_code_d    = fail_code;
    cycle_count_d  = cycle_count;

    if (hit_reset) begin
      state_d        = S_HOLD;
      hold_cnt_d     = '0;
      core_reset_n_d = 1'b0;
      done_d         = 1'b0;
      pass_d         = 1'b0;
      timeout_d      = 1'b0;
      fail_code_d    = '0;
      cycle_count_d  = '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state_d        = S_RUN;
            hold_cnt_d     = '0;
            core_reset_n_d = 1'b1;
            cycle_count_d  = '0;
          end else begin
            hold_cnt_d = hold_cnt + HOLD_W'(1);
          end
        end
        S_RUN: begin
          // A verdict on the last budgeted cycle beats the timeout.
          if (mbox_hit) begin
            cycle_count_d = cycle_count + CNT_W'(1);
            done_d        = 1'b1;
            if (mem_data == DATA_W'(1)) begin
              state_d = S_PASS;
              pass_d  = 1'b1;
            end else begin
              state_d     = S_FAIL;
              fail_code_d = mem_data[DATA_W-1:1];
            end
          end else if (cycle_count == CNT_LAST) begin
            state_d   = S_TIMEOUT;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end else begin
            cycle_count_d = cycle_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end

    running_d = (state_d == S_RUN);
  end

endmodule
